// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// Handles one operation at a time: accept in IDLE, one quotient bit per BUSY cycle, hold the result in DONE.
module iter_div_unit #(
  parameter int XLEN       = 64,
  parameter int EU_CTL_LEN = 2,
  parameter int RS_IDX_LEN = 4,
  parameter int EXCEPT_LEN = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [EU_CTL_LEN-1:0] ctl_i,
  input  logic [XLEN-1:0]       rs1_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [RS_IDX_LEN-1:0] entry_idx_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       result_o,
  output logic [RS_IDX_LEN-1:0] entry_idx_o,
  output logic                  except_raised_o,
  output logic [EXCEPT_LEN-1:0] except_code_o
);

  localparam int CW = $clog2(XLEN);
  localparam int RW = XLEN + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [EU_CTL_LEN-1:0] ctl_q;
  logic [RS_IDX_LEN-1:0] idx_q;
  logic [XLEN-1:0]       dvd_q, dvs_q, result_q;
  logic [XLEN:0]         rem_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q_q, neg_r_q;

  logic                  accept, in_signed, div_zero, overflow, special;
  logic [XLEN-1:0]       abs_rs1, abs_rs2, special_res, quo_nxt;
  logic [XLEN:0]         rem_nxt;
  logic                  take;

  assign accept    = valid_i && !flush_i;
  assign in_signed = !ctl_i[0];
  assign abs_rs1   = (in_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign abs_rs2   = (in_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
  assign div_zero  = (rs2_i == '0);
  assign overflow  = in_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign special   = div_zero || overflow;

  // Quotient for x/0 is all ones and remainder is x; signed MIN/-1 gives MIN and 0.
  assign special_res = ctl_i[1] ? (div_zero ? rs1_i : '0)
                                : (div_zero ? '1    : rs1_i);

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign take    = {rem_q, dvd_q[XLEN-1]} >= {2'b00, dvs_q};
  assign rem_nxt = take ? RW'({rem_q, dvd_q[XLEN-1]} - {2'b00, dvs_q})
                        : RW'({rem_q, dvd_q[XLEN-1]});
  assign quo_nxt = {dvd_q[XLEN-2:0], take};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)        state_d = special ? S_DONE : S_BUSY;
      S_BUSY: if (cnt_q == '0)   state_d = S_DONE;
      S_DONE: if (ready_i)       state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // NOTE: datapath registers are reset too, so result_o/entry_idx_o read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctl_q    <= '0;
      idx_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else if (!flush_i) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      unique case (state_q)
        S_IDLE: if (valid_i) begin
          ctl_q    <= ctl_i;
          idx_q    <= entry_idx_i;
          dvd_q    <= abs_rs1;
          dvs_q    <= abs_rs2;
          rem_q    <= '0;
          cnt_q    <= CW'(XLEN - 1);
          neg_q_q  <= in_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
          neg_r_q  <= in_signed && rs1_i[XLEN-1];
          if (special) result_q <= special_res;
        end
        S_BUSY: begin
          rem_q <= rem_nxt;
          dvd_q <= quo_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0)
            result_q <= ctl_q[1] ? XLEN'(neg_r_q ? -rem_nxt : rem_nxt)
                                 : (neg_q_q ? -quo_nxt : quo_nxt);
        end
        default: ;
      endcase
    end
  end

  assign ready_o         = (state_q == S_IDLE);
  assign valid_o         = (state_q == S_DONE);
  assign result_o        = result_q;
  assign entry_idx_o     = idx_q;
  assign except_raised_o = 1'b0;
  assign except_code_o   = '0;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed self-checking bench for iter_div_unit (XLEN=64).
// Each scenario task drives its stimulus and compares against hand-computed values.
module tb_iter_div_unit;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  ctl_i = '0;
  logic [63:0] rs1_i = '0;
  logic [63:0] rs2_i = '0;
  logic [3:0]  entry_idx_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [63:0] result_o;
  logic [3:0]  entry_idx_o;
  logic        except_raised_o;
  logic [1:0]  except_code_o;

  int n_cmp = 0;
  int n_bad = 0;

  iter_div_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .ctl_i(ctl_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .entry_idx_i(entry_idx_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .entry_idx_o(entry_idx_o), .except_raised_o(except_raised_o),
    .except_code_o(except_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one operation for exactly one edge; returns 1 ns after that edge.
  task automatic issue(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] idx);
    @(negedge clk_i);
    ctl_i = c; rs1_i = a; rs2_i = b; entry_idx_i = idx; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  // Edges from the accepting edge until valid_o is seen (1 = first edge); capped at 200.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk_i); ready_i = 1'b1;
    @(posedge clk_i); #1; ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (result_o !== 64'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
    n_cmp++; if (entry_idx_o !== 4'h0) begin n_bad++; $display("FAIL reset_idx: got %h want 0", entry_idx_o); end
    n_cmp++; if ({except_raised_o, except_code_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_except: got %b%b want 000", except_raised_o, except_code_o); end
    @(negedge clk_i); rst_n_i = 1'b1;
  endtask

  // Table of ordinary and special operations, retired back to back.
  task automatic test_arith();
    logic [1:0]  c   [10];
    logic [63:0] a   [10];
    logic [63:0] b   [10];
    logic [63:0] exp [10];
    int          elat[10];
    int          lat;
    c[0]=OP_DIV;  a[0]=-64'sd7;  b[0]=64'd2;     exp[0]=-64'sd3;  elat[0]=65;
    c[1]=OP_REM;  a[1]=-64'sd7;  b[1]=64'd2;     exp[1]=ONES;     elat[1]=65;
    c[2]=OP_DIVU; a[2]=64'd100;  b[2]=64'd7;     exp[2]=64'd14;   elat[2]=65;
    c[3]=OP_REMU; a[3]=64'd100;  b[3]=64'd7;     exp[3]=64'd2;    elat[3]=65;
    c[4]=OP_DIV;  a[4]=64'd7;    b[4]=-64'sd2;   exp[4]=-64'sd3;  elat[4]=65;
    c[5]=OP_REM;  a[5]=64'd7;    b[5]=-64'sd2;   exp[5]=64'd1;    elat[5]=65;
    c[6]=OP_DIVU; a[6]=ONES;     b[6]=64'd2;     exp[6]=64'h7FFF_FFFF_FFFF_FFFF; elat[6]=65;
    c[7]=OP_DIV;  a[7]=64'd1234; b[7]=64'd0;     exp[7]=ONES;     elat[7]=1;
    c[8]=OP_REM;  a[8]=64'd1234; b[8]=64'd0;     exp[8]=64'd1234; elat[8]=1;
    c[9]=OP_DIV;  a[9]=MIN64;    b[9]=ONES;      exp[9]=MIN64;    elat[9]=1;
    for (int i = 0; i < 10; i++) begin
      issue(c[i], a[i], b[i], 4'(i + 1));
      wait_valid(lat);
      n_cmp++; if (lat !== elat[i]) begin n_bad++; $display("FAIL op%0d_latency: got %0d want %0d", i, lat, elat[i]); end
      n_cmp++; if (result_o !== exp[i]) begin n_bad++; $display("FAIL op%0d_result: got %h want %h", i, result_o, exp[i]); end
      n_cmp++; if (entry_idx_o !== 4'(i + 1)) begin n_bad++; $display("FAIL op%0d_idx: got %h want %h", i, entry_idx_o, 4'(i + 1)); end
      n_cmp++; if (except_raised_o !== 1'b0) begin n_bad++; $display("FAIL op%0d_except: got %b want 0", i, except_raised_o); end
      retire();
      n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
        n_bad++; $display("FAIL op%0d_retire: got ready=%b valid=%b want 1/0", i, ready_o, valid_o); end
    end
    // Signed MIN % -1 = 0, also a one-cycle special case.
    issue(OP_REM, MIN64, ONES, 4'h5);
    wait_valid(lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rem_ovf_latency: got %0d want 1", lat); end
    n_cmp++; if (result_o !== 64'h0) begin n_bad++; $display("FAIL rem_ovf_result: got %h want 0", result_o); end
    retire();
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    issue(OP_DIVU, 64'd100, 64'd7, 4'h6);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_busy: got ready=%b valid=%b want 1/0", ready_o, valid_o); end
    repeat (80) begin @(posedge clk_i); #1; if (valid_o) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_result: got valid seen=%b want 0", seen); end
    // Flush outranks a simultaneous accept (a divide-by-zero would otherwise finish in 1 cycle).
    @(negedge clk_i);
    ctl_i = OP_DIV; rs1_i = 64'd9; rs2_i = 64'd0; entry_idx_i = 4'h7; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1; valid_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_bad++; $display("FAIL flush_vs_accept: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
  endtask

  task automatic test_hold();
    int lat;
    issue(OP_DIVU, 64'd100, 64'd7, 4'hA);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      n_cmp++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 64'd14 || entry_idx_o !== 4'hA) begin
        n_bad++; $display("FAIL hold_cycle%0d: got valid=%b ready=%b result=%h idx=%h want 1/0/e/a",
                          k, valid_o, ready_o, result_o, entry_idx_o); end
    end
    retire();
    n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: got ready=%b valid=%b want 1/0", ready_o, valid_o); end
  endtask

  task automatic test_async_reset();
    int lat;
    issue(OP_DIV, -64'sd7, 64'd2, 4'hC);
    repeat (5) @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 64'h0 || entry_idx_o !== 4'h0) begin
      n_bad++; $display("FAIL async_reset: got ready=%b valid=%b result=%h idx=%h want 1/0/0/0",
                        ready_o, valid_o, result_o, entry_idx_o); end
    @(negedge clk_i); rst_n_i = 1'b1;
    issue(OP_REMU, 64'd100, 64'd7, 4'h3);
    wait_valid(lat);
    n_cmp++; if (lat !== 65 || result_o !== 64'd2) begin
      n_bad++; $display("FAIL after_reset_op: got lat=%0d result=%h want 65/2", lat, result_o); end
    retire();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_flush();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
